// File: rtl/cycle_counter_pkg.sv
// Mode encodings and mode-decode helpers shared by the cycle_counter slice.
// Optional prescaler is enabled with CYCLE_COUNTER_PRESCALE_EN (see cycle_counter.sv).
package cycle_counter_pkg;

  localparam logic [1:0] CNT_MODE_PUP = 2'b00;
  localparam logic [1:0] CNT_MODE_PDN = 2'b01;
  localparam logic [1:0] CNT_MODE_OUP = 2'b10;
  localparam logic [1:0] CNT_MODE_ODN = 2'b11;

  function automatic logic is_down(input logic [1:0] mode);
    return mode[0];
  endfunction

  function automatic logic is_oneshot(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/cycle_counter_prescaler.sv
// Enable prescaler for cycle_counter: emits tick on the enabled cycle where the count reaches presc.
// Only compiled when CYCLE_COUNTER_PRESCALE_EN is defined.
`ifdef CYCLE_COUNTER_PRESCALE_EN
module cnt_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // >= rather than == so lowering presc below the running count fires at once
  assign tick = en && (cnt_q >= presc);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/cycle_counter.sv
// Multi-mode up/down, periodic/one-shot cycle counter with tc pulse and sticky done.
// Define CYCLE_COUNTER_PRESCALE_EN to add the presc input and enable prescaler.
module cycle_counter
  import cycle_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int RELOAD = 2
`ifdef CYCLE_COUNTER_PRESCALE_EN
  ,
  parameter int PRESC_W = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max,
  input  logic [1:0]       mode,
`ifdef CYCLE_COUNTER_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc,
`endif
  output logic [WIDTH-1:0] val,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] RELOAD_V = WIDTH'(RELOAD);

  logic [WIDTH-1:0] val_q, val_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             advance;

`ifdef CYCLE_COUNTER_PRESCALE_EN
  logic presc_tick;

  cnt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .clr   (rst | clear | load),
    .en    (en),
    .presc (presc),
    .tick  (presc_tick)
  );

  assign advance = presc_tick;
`else
  assign advance = en;
`endif

  logic [WIDTH-1:0] val_inc, val_dec;
  logic             up_hit, dn_hit;

  // up_hit is checked before val_inc is used, so max=all-ones never overflows
  assign val_inc = val_q + WIDTH'(1);
  assign val_dec = val_q - WIDTH'(1);
  assign up_hit  = (val_q >= max);
  assign dn_hit  = (val_q == '0);

  always_comb begin
    val_d  = val_q;
    tc_d   = 1'b0;
    done_d = done_q;
    if (clear) begin
      val_d  = '0;
      done_d = 1'b0;
    end else if (load) begin
      val_d  = load_val;
      done_d = 1'b0;
    end else if (advance) begin
      if (!is_oneshot(mode)) begin
        if (!is_down(mode)) begin
          if (!up_hit) val_d = val_inc;
          else begin
            val_d = RELOAD_V;
            tc_d  = 1'b1;
          end
        end else begin
          if (!dn_hit) val_d = val_dec;
          else begin
            val_d = max;
            tc_d  = 1'b1;
          end
        end
      end else if (!is_down(mode)) begin
        if (!up_hit) begin
          val_d = val_inc;
          if (val_inc == max) begin
            tc_d   = 1'b1;
            done_d = 1'b1;
          end
        end else if (!done_q) begin
          tc_d   = 1'b1;
          done_d = 1'b1;
        end
      end else begin
        if (!dn_hit) begin
          val_d = val_dec;
          if (val_dec == '0) begin
            tc_d   = 1'b1;
            done_d = 1'b1;
          end
        end else if (!done_q) begin
          tc_d   = 1'b1;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      tc_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      tc_q   <= tc_d;
      done_q <= done_d;
    end
  end

  assign val  = val_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: doc/cycle_counter.md
Name: cycle_counter

Overview:
- Parametrised, multi-mode successor to the fixed 8-bit wrap counter.
- Counts up or down, periodic or one-shot, with runtime limit, runtime load and programmable restart value.
- Emits a one-cycle terminal-count pulse and a sticky done flag.
- Serves pipeline stall/timeout timers, CSR-visible cycle timers and delay sequencing in the core.

Parameters:
- WIDTH, 8, counter/limit width in bits.
- RELOAD, 2, restart value after a periodic up-count wrap; must be < 2^WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; when low, the value holds.
- clear  in  1  synchronous clear of value and flags.
- load  in  1  load load_val into the counter.
- load_val  in  WIDTH  value for load.
- max  in  WIDTH  runtime limit (terminal value up, reload value down).
- mode  in  2  00 periodic-up, 01 periodic-down, 10 one-shot-up, 11 one-shot-down.
- val  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, exactly one cycle.
- done  out  1  one-shot finished, sticky.

Behaviour:
- Reset: synchronous, active-high. rst=1 at an edge gives val=0, tc=0, done=0, and the prescaler count returns to 0.
- Priority per edge: rst > clear > load > en.
- clear: val=0, tc=0, done=0.
- load: val=load_val, tc=0, done=0. Applies even when en=0.
- en=0 (and no rst/clear/load): val and done hold, tc=0.
- Periodic-up: if val < max then val+1; else (val >= max) val=RELOAD and tc=1.
  - If RELOAD > max, the wrap still loads RELOAD; the next enabled cycle wraps again.
- Periodic-down: if val > 0 then val-1; else val=max and tc=1.
  - A val above max simply decrements.
- One-shot-up: if val < max then val+1.
  - The increment that reaches max sets tc=1 and done=1 in that same cycle.
  - Further enabled cycles hold val=max, keep done=1, tc=0.
- One-shot-down: same as one-shot-up, counting toward 0.
- tc is asserted in the same cycle val shows the post-event value (wrap value or terminal value). It never stays high two consecutive cycles in one-shot modes.
- One-shot started at the terminal value (val==max up, val==0 down) with done=0: the first enabled cycle sets done=1 and tc=1 without changing val.
- Changing mode or max mid-count: takes effect on the next edge; val is not altered. Lowering max below val in up modes causes an immediate wrap (periodic) or termination (one-shot).
- Arithmetic: all compare/increment at WIDTH bits, unsigned. val+1 at max=2^WIDTH-1 is never computed, because the compare catches it first.
- Latency: one cycle from input to val/tc/done. No combinational input-to-output paths.

Optional Feature:
- Macro: CYCLE_COUNTER_PRESCALE_EN.
- With the macro:
  - Adds parameter PRESC_W (default 4) and input presc[PRESC_W-1:0].
  - An internal prescaler increments on each en=1 cycle. The counter advances (and tc/done may fire) only on the enabled cycle where the prescaler equals presc, which also resets the prescaler to 0.
  - presc=0 behaves identically to the macro-off build.
  - clear, load and rst also zero the prescaler.
  - Changing presc mid-count: if the prescaler count already exceeds the new value, the next enabled cycle treats it as a match.
- Without the macro: no presc port; the counter advances on every en=1 cycle.

Decomposition:
- Shared defines file holds the mode encodings: CNT_MODE_PUP=2'b00, CNT_MODE_PDN=2'b01, CNT_MODE_OUP=2'b10, CNT_MODE_ODN=2'b11, plus derived is_down = mode[0] and is_oneshot = mode[1].
- One natural sub-module: cnt_prescaler (PRESC_W counter, en/presc/clr in, tick out), instantiated only under CYCLE_COUNTER_PRESCALE_EN.
- Direction/terminal logic stays in cycle_counter.

Test Plan:
- Reset and defaults: assert rst for 2 cycles mid-count at val=5 -> val=0, tc=0, done=0 on the first edge after rst rises.
- Periodic-up wrap: WIDTH=8, RELOAD=2, max=5, en=1 from val=0 -> val 1,2,3,4,5,2,3,4,5,2; tc high only with each val=2 following 5.
- Periodic-down plus load: load_val=3, mode=01, max=6 -> val 3,2,1,0,6,5; tc high only with val=6. Assert clear and load together -> val=0 (clear wins).
- One-shot-up: max=3 from val=0 -> val 1,2,3,3,3; tc and done rise with val=3, tc drops next cycle, done stays. Then load_val=1 -> done=0 and counting restarts.
- Boundaries:
  - WIDTH=4, max=15, periodic-up, from val=14 -> val 15 then RELOAD, no overflow.
  - Lower max from 10 to 4 while val=7 -> next enabled cycle wraps to RELOAD with tc=1.
  - en low for 3 cycles -> val holds, tc=0.
- Prescale build: presc=2, max=2, periodic-up from 0 -> val changes every 3rd enabled cycle (0,0,0,1,1,1,2,...). presc=0 matches the non-prescale trace cycle-for-cycle.
